score_bcd_counter: RTL and testbench
====================================

SCORE_BCD_COUNTER -- requirements
Module: score_bcd_counter

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 25000, meaning clk cycles per scan_en pulse (100 MHz / 4 kHz); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port clear  input  1  synchronous score clear, active-high.
REQ-005 SHALL have port pts_valid  input  1  points-award request.
REQ-006 SHALL have port pts  input  2  points to add (0..3), sampled with pts_valid.
REQ-007 SHALL have port pts_ready  output  1  high when a request can be accepted.
REQ-008 SHALL have port d1  output  4  tens digit, BCD 0..9.
REQ-009 SHALL have port d0  output  4  ones digit, BCD 0..9.
REQ-010 SHALL have port sat  output  1  sticky flag: a point was lost at 99.
REQ-011 SHALL have port scan_en  output  1  one-cycle digit-scan pulse for the display multiplexer.

Function
REQ-012 Score SHALL be held as two BCD digits {d1,d0}, range 00..99; d1 and d0 SHALL never hold 10..15.
REQ-013 FSM SHALL have exactly two states: IDLE and ADD.
REQ-014 pts_ready SHALL be 1 in IDLE and 0 in ADD, driven from registered state only.
REQ-015 A request SHALL be accepted on a clk edge where pts_valid=1, pts_ready=1 and clear=0.
REQ-016 Accepted pts=0 SHALL be a no-op; the FSM stays in IDLE.
REQ-017 Accepted pts=1..3 SHALL load remaining count rem=pts and move the FSM to ADD.
REQ-018 In ADD, each cycle SHALL add exactly one to the score and decrement rem.
REQ-019 The FSM SHALL return to IDLE on the cycle rem goes 1->0; a request of N points therefore occupies N cycles in ADD, and pts_ready returns high N cycles after acceptance.
REQ-020 BCD increment SHALL apply: d0<9 -> d0+1; d0=9, d1<9 -> d0=0, d1+1.
REQ-021 At 99, an increment SHALL leave the score at 99, set sat=1, clear rem and return to IDLE (saturate, no wrap).
REQ-022 sat SHALL remain 1 until clear or reset.
REQ-023 Digits SHALL update on the clk edge that performs the increment; no further output pipeline.
REQ-024 clear=1 SHALL have priority over all other inputs: next edge sets d1=d0=0, sat=0, rem=0, FSM=IDLE, and discards any in-progress request.
REQ-025 A request with pts_valid and clear both high SHALL be dropped (not accepted).
REQ-026 pts_valid while pts_ready=0 SHALL be ignored; the upstream holds it until accepted.
REQ-027 scan_en SHALL pulse high for exactly one cycle every SCAN_DIV cycles, free-running.
REQ-028 scan_en SHALL be unaffected by clear or FSM activity.
REQ-029 The first scan_en pulse after reset release SHALL occur on the SCAN_DIV-th clk edge.

Reset
REQ-030 rst_n=0 SHALL asynchronously force d1=0, d0=0, sat=0, rem=0, FSM=IDLE (pts_ready=1), scan_en=0 and scan counter=0.
REQ-031 Reset asserted mid-ADD SHALL abort the addition with no partial-state residue after release.
REQ-032 After rst_n deasserts, a request SHALL be acceptable on the first clk edge.

Structure
REQ-033 FSM state encoding, BCD_MAX (4'd9) and the SCAN_DIV default SHALL live in shared package sevenseg_pkg, for reuse by the display path.
REQ-034 The scan pulse generator SHALL be one sub-module, scan_tick_gen (parameter SCAN_DIV; ports clk, rst_n, tick).
REQ-035 The BCD increment and FSM SHALL stay in score_bcd_counter; there SHALL be no other sub-modules.

Verification (bench uses SCAN_DIV=8)
REQ-036 Reset, then pts=2 accepted -> pts_ready low 2 cycles; d1=0, d0=2 after 2nd edge; sat=0.
REQ-037 Score 08, pts=3 -> digits step 09, 10, 11 on consecutive edges; d0 never exceeds 9.
REQ-038 Score 98, pts=3 -> 99 after 1 cycle, then sat=1, IDLE on next edge; score stays 99.
REQ-039 clear asserted during 2nd cycle of a pts=3 add -> next edge 00, sat=0, pts_ready=1; no further increments.
REQ-040 rst_n pulsed low mid-ADD, asynchronously between edges -> outputs 00, pts_ready=1 immediately, without waiting for a clk edge.
REQ-041 Free-run 100 cycles -> scan_en high exactly on cycles 8, 16, ..., 96, one cycle each, with random pts and clear traffic applied.

Source files
------------

// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the score counter and the seven-segment display path.
package sevenseg_pkg;

  localparam int unsigned DIGIT_W          = 4;
  localparam int unsigned PTS_W            = 2;
  localparam int unsigned SCAN_CNT_W       = 16;
  localparam int unsigned SCAN_DIV_DEFAULT = 25000;

  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ADD  = 1'b1
  } state_t;

  typedef struct packed {
    logic [DIGIT_W-1:0] d1;
    logic [DIGIT_W-1:0] d0;
  } score_t;

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider: one-cycle tick every SCAN_DIV clocks, first tick on the SCAN_DIV-th edge.
module scan_tick_gen
  import sevenseg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam logic [SCAN_CNT_W-1:0] LAST = SCAN_CNT_W'(SCAN_DIV - 1);

  logic [SCAN_CNT_W-1:0] cnt;

  // Count 0..SCAN_DIV-1 and register the wrap as the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == LAST) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + SCAN_CNT_W'(1);
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Two-digit BCD score counter: accepts 0..3 point awards, adds one point per cycle, saturates at 99.
module score_bcd_counter
  import sevenseg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               pts_valid,
  input  logic [PTS_W-1:0]   pts,
  output logic               pts_ready,
  output logic [DIGIT_W-1:0] d1,
  output logic [DIGIT_W-1:0] d0,
  output logic               sat,
  output logic               scan_en
);

  state_t           state;
  score_t           score;
  score_t           score_inc;
  logic             at_max;
  logic [PTS_W-1:0] rem;
  logic             ready;

  assign d1        = score.d1;
  assign d0        = score.d0;
  assign pts_ready = ready;

  // Next BCD value of the score (only used when not already at 99).
  always_comb begin
    score_inc = score;
    at_max    = (score.d1 == BCD_MAX) && (score.d0 == BCD_MAX);
    if (score.d0 < BCD_MAX) begin
      score_inc.d0 = score.d0 + DIGIT_W'(1);
    end else if (score.d1 < BCD_MAX) begin
      score_inc.d0 = '0;
      score_inc.d1 = score.d1 + DIGIT_W'(1);
    end
  end

  // Request acceptance, per-cycle increment, saturation and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      score <= '0;
      rem   <= '0;
      sat   <= 1'b0;
      ready <= 1'b1;
    end else if (clear) begin
      state <= ST_IDLE;
      score <= '0;
      rem   <= '0;
      sat   <= 1'b0;
      ready <= 1'b1;
    end else if (state == ST_IDLE) begin
      if (pts_valid && (pts != '0)) begin
        rem   <= pts;
        state <= ST_ADD;
        ready <= 1'b0;
      end
    end else begin
      if (at_max) begin
        sat   <= 1'b1;
        rem   <= '0;
        state <= ST_IDLE;
        ready <= 1'b1;
      end else begin
        score <= score_inc;
        rem   <= rem - PTS_W'(1);
        if (rem == PTS_W'(1)) begin
          state <= ST_IDLE;
          ready <= 1'b1;
        end
      end
    end
  end

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (scan_en)
  );

endmodule

// File: tb/tb_score_bcd_counter.sv
// Self-checking bench for score_bcd_counter: integer score model plus directed literal checks.
module tb_score_bcd_counter;

  localparam int unsigned DIV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       pts_valid = 1'b0;
  logic [1:0] pts = 2'd0;
  logic       pts_ready;
  logic [3:0] d1;
  logic [3:0] d0;
  logic       sat;
  logic       scan_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: plain integer score and pending-point count.
  int m_score = 0;
  int m_rem   = 0;
  int m_sat   = 0;
  int m_edges = 0;

  score_bcd_counter #(
    .SCAN_DIV (DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .pts_valid (pts_valid),
    .pts       (pts),
    .pts_ready (pts_ready),
    .d1        (d1),
    .d0        (d0),
    .sat       (sat),
    .scan_en   (scan_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the rules: a request loads points, each busy cycle adds one, 99 saturates.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0; m_rem = 0; m_sat = 0; m_edges = 0;
    end else begin
      m_edges++;
      if (clear) begin
        m_score = 0; m_rem = 0; m_sat = 0;
      end else if (m_rem == 0) begin
        if (pts_valid) m_rem = int'(pts);
      end else if (m_score == 99) begin
        m_sat = 1; m_rem = 0;
      end else begin
        m_score++; m_rem--;
      end
    end
  end

  // Compare every DUT output with the model on each falling edge.
  always @(negedge clk) begin
    chk("d1", int'(d1), m_score / 10);
    chk("d0", int'(d0), m_score % 10);
    chk("sat", int'(sat), m_sat);
    chk("pts_ready", int'(pts_ready), (m_rem == 0) ? 1 : 0);
    chk("scan_en", int'(scan_en), (m_edges > 0 && (m_edges % DIV) == 0) ? 1 : 0);
  end

  // Advance to 2 ns after the next rising edge.
  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Present inputs for exactly one edge.
  task automatic step(input logic v, input logic [1:0] p, input logic c);
    pts_valid = v; pts = p; clear = c;
    tick();
    pts_valid = 1'b0; pts = 2'd0; clear = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!pts_ready && n < 20) begin
      tick(); n++;
    end
    if (!pts_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic award(input logic [1:0] p);
    wait_ready();
    step(1'b1, p, 1'b0);
    wait_ready();
  endtask

  initial begin
    int pulses;
    // Reset and first request on the first edge after release.
    #12;
    rst_n = 1'b1;
    chk("reset_ready", int'(pts_ready), 1);
    chk("reset_d0", int'(d0), 0);
    step(1'b1, 2'd2, 1'b0);
    chk("p2_busy1", int'(pts_ready), 0);
    chk("p2_d0_0", int'(d0), 0);
    tick();
    chk("p2_busy2", int'(pts_ready), 0);
    chk("p2_d0_1", int'(d0), 1);
    tick();
    chk("p2_ready", int'(pts_ready), 1);
    chk("p2_d0_2", int'(d0), 2);
    chk("p2_sat", int'(sat), 0);

    // 08 + 3 rolls the tens digit.
    step(1'b0, 2'd0, 1'b1);
    award(2'd3); award(2'd3); award(2'd2);
    chk("s08", int'({d1, d0}), 8'h08);
    step(1'b1, 2'd3, 1'b0);
    tick(); chk("s09", int'({d1, d0}), 8'h09);
    tick(); chk("s10", int'({d1, d0}), 8'h10);
    tick(); chk("s11", int'({d1, d0}), 8'h11);
    chk("s11_ready", int'(pts_ready), 1);

    // 98 + 3 saturates at 99.
    step(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 32; i++) award(2'd3);
    award(2'd2);
    chk("s98", int'({d1, d0}), 8'h98);
    step(1'b1, 2'd3, 1'b0);
    tick();
    chk("s99", int'({d1, d0}), 8'h99);
    chk("s99_sat0", int'(sat), 0);
    tick();
    chk("sat_set", int'(sat), 1);
    chk("sat_ready", int'(pts_ready), 1);
    chk("sat_hold", int'({d1, d0}), 8'h99);
    award(2'd1);
    chk("sat_sticky", int'(sat), 1);
    chk("sat_hold2", int'({d1, d0}), 8'h99);

    // Clear during the second cycle of a 3-point add.
    step(1'b0, 2'd0, 1'b1);
    chk("clr_sat", int'(sat), 0);
    step(1'b1, 2'd3, 1'b0);
    tick();
    chk("clr_pre", int'({d1, d0}), 8'h01);
    step(1'b0, 2'd0, 1'b1);
    chk("clr_zero", int'({d1, d0}), 8'h00);
    chk("clr_ready", int'(pts_ready), 1);
    tick();
    chk("clr_noinc", int'({d1, d0}), 8'h00);

    // Asynchronous reset mid-add.
    step(1'b1, 2'd3, 1'b0);
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_digits", int'({d1, d0}), 8'h00);
    chk("arst_ready", int'(pts_ready), 1);
    chk("arst_sat", int'(sat), 0);
    chk("arst_scan", int'(scan_en), 0);
    #1;
    rst_n = 1'b1;
    step(1'b1, 2'd1, 1'b0);
    chk("arst_accept", int'(pts_ready), 0);
    tick();
    chk("arst_d0", int'(d0), 1);

    // Random traffic after a fresh reset; count scan pulses over 100 edges.
    @(negedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 100; c++) begin
      pts_valid = 1'($urandom_range(0, 1));
      pts       = 2'($urandom_range(0, 3));
      clear     = ($urandom_range(0, 15) == 0);
      @(posedge clk); #2;
      if (scan_en) pulses++;
    end
    pts_valid = 1'b0; clear = 1'b0;
    chk("scan_pulses", pulses, 12);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
